// File: rtl/demux1x4_tdm.sv
// Receive end of a 4-slot TDM link: realigns on the slot-0 sync marker and
// presents each complete frame on four parallel lanes, updated atomically.
module demux1x4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] stg0_q, stg0_d, stg1_q, stg1_d, stg2_q, stg2_d;
  logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic             ov_q, ov_d, lk_q, lk_d, serr_q, serr_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic             err_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      stg0_q  <= '0;
      stg1_q  <= '0;
      stg2_q  <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      ov_q    <= 1'b0;
      lk_q    <= 1'b0;
      serr_q  <= 1'b0;
      ecnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      stg0_q  <= stg0_d;
      stg1_q  <= stg1_d;
      stg2_q  <= stg2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      ov_q    <= ov_d;
      lk_q    <= lk_d;
      serr_q  <= serr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    stg0_d  = stg0_q;
    stg1_d  = stg1_q;
    stg2_d  = stg2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    ov_d    = 1'b0;
    err_hit = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sync) begin
            stg0_d  = in_data;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q == 2'd0) begin
            if (in_sync) begin
              stg0_d = in_data;
              slot_d = 2'd1;
            end else begin
              err_hit = 1'b1;
              state_d = HUNT;
            end
          end else if (in_sync) begin
            // Early sync: abandon the partial frame and restart at slot 0.
            err_hit = 1'b1;
            stg0_d  = in_data;
            slot_d  = 2'd1;
          end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
              2'd1: stg1_d = in_data;
              2'd2: stg2_d = in_data;
              default: begin
                y0_d = stg0_q;
                y1_d = stg1_q;
                y2_d = stg2_q;
                y3_d = in_data;
                ov_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
    lk_d   = (state_d == LOCKED);
    serr_d = err_hit;
    ecnt_d = (err_hit && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  end

  assign Y0        = y0_q;
  assign Y1        = y1_q;
  assign Y2        = y2_q;
  assign Y3        = y3_q;
  assign out_valid = ov_q;
  assign locked    = lk_q;
  assign sync_err  = serr_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: doc/demux1x4_tdm.md
Name: demux1x4_tdm

Overview:
- Sequential 1-to-4 time-division demultiplexer: the receive end of a 4-slot TDM link whose transmit end selects one of four inputs per slot onto a shared line.
- Accepts a stream of WIDTH-bit samples with a slot-0 sync marker.
- De-interleaves each 4-slot frame into four parallel lane outputs, updated together.
- Detects sync loss and recovers alignment.

Parameters:
- WIDTH, 8, bit width of each sample and of each lane output.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  multiplexed sample for the current slot.
- in_valid  input  1  in_data/in_sync are sampled only when high.
- in_sync  input  1  marks the sample as slot 0 of a frame; meaningful only with in_valid.
- Y0  output  WIDTH  lane 0 (slot 0) of the last complete frame.
- Y1  output  WIDTH  lane 1 (slot 1) of the last complete frame.
- Y2  output  WIDTH  lane 2 (slot 2) of the last complete frame.
- Y3  output  WIDTH  lane 3 (slot 3) of the last complete frame.
- out_valid  output  1  one-cycle pulse: Y0..Y3 were just updated with a new frame.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on any sync violation.
- err_cnt  output  8  saturating count of sync violations.

Behaviour:
- Reset, asynchronous, any time including mid-frame:
  - State goes to HUNT and the slot counter to 0.
  - The staging registers, Y0..Y3, out_valid, locked, sync_err and err_cnt all go to 0.
  - The partial frame is discarded.
- All outputs are registered.
- Nothing changes on an edge with in_valid low. out_valid and sync_err deassert after their single pulse cycle.
- HUNT state:
  - Samples without in_sync are dropped silently, with no error.
  - A sample with in_valid and in_sync is stored in staging[0], the slot counter goes to 1, and the state goes to LOCKED (locked=1 from the next cycle).
- LOCKED state, on each in_valid edge with slot counter s:
  - s=0 with in_sync=1: normal start of frame. Store in staging[0], s goes to 1.
  - s in 1..3 with in_sync=0: normal. Store in staging[s].
    - If s<3, s goes to s+1.
    - If s=3, on the same edge Y0..Y2 take staging[0..2] and Y3 takes in_data, all four atomically. s wraps to 0. out_valid is high for the following cycle.
  - s in 1..3 with in_sync=1 (early sync):
    - sync_err pulses and err_cnt increments.
    - The partial frame is discarded and Y0..Y3 are unchanged.
    - The sample is stored in staging[0] as a new slot 0, s goes to 1, and the state stays LOCKED.
  - s=0 with in_sync=0 (missing sync):
    - sync_err pulses, err_cnt increments and the sample is dropped.
    - The state goes to HUNT and locked deasserts.
- err_cnt saturates at 255 and never wraps. It is cleared only by reset.
- Latency: Y0..Y3 update on the edge that samples slot 3, and out_valid is coincident with the new values. Back-to-back frames with in_valid continuously high give one out_valid every 4 cycles.
- Gaps: in_valid may drop between any slots. The frame then completes on the 4th accepted sample regardless of elapsed cycles.
- Y0..Y3 hold their values between frames and after entering HUNT.

Test Plan:
- Reset, then in_valid=1 with samples 0x11(sync), 0x22, 0x33, 0x44 on consecutive edges -> out_valid one cycle after the 4th edge; Y0..Y3 = 0x11, 0x22, 0x33, 0x44; locked=1; sync_err never high.
- Same frame with in_valid low for 3 cycles between slots 1 and 2 -> identical Y values; out_valid only after the 4th accepted sample; no error.
- Locked, then 0xA0(sync), 0xA1, 0xB0(sync), 0xB1, 0xB2, 0xB3 -> sync_err pulses once at 0xB0; err_cnt=1; Y = 0xB0, 0xB1, 0xB2, 0xB3; the 0xA frame is never output.
- After a complete frame, send 0x55 without sync at slot 0 -> sync_err pulse; locked=0; Y unchanged; then 0x01(sync), 0x02, 0x03, 0x04 -> relock; Y = 0x01, 0x02, 0x03, 0x04.
- Assert rst after slot 2 of a frame -> all outputs 0 immediately (asynchronous); the following 2 samples without sync produce no output and no error.
- 300 consecutive early-sync violations -> err_cnt stops at 255.
